// File: rtl/rx_deser_param_pkg.sv
// Shared types and helpers for the parametrised RX deserializer.
// The optional parity feature is controlled by RX_DESER_PARITY_EN (see rx_deser_param.sv).
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_deser_state_e;

    localparam int MIN_DATA_LEN = 5;
    localparam int DATA_W_DEF   = 8;

    // Out-of-range frame lengths fall back to the full word width.
    function automatic int clamp_len(input int len, input int max_len);
        if (len < MIN_DATA_LEN || len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/rx_deser_param_if.sv
// Bundle between the RX FSM/sampler side (master) and the deserializer (slave).
// par_odd/par_calc exist only when RX_DESER_PARITY_EN is defined.
interface rx_deser_if #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6,
    parameter int LEN_W      = $clog2(DATA_W + 1)
);
    logic                  deser_en;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] prescale;
    logic                  sampled_bit;
    logic [LEN_W-1:0]      data_len;
    logic                  msb_first;
    logic [DATA_W-1:0]     P_DATA;
    logic                  data_done;
    logic                  busy;
`ifdef RX_DESER_PARITY_EN
    logic                  par_odd;
    logic                  par_calc;
`endif

    modport master (
        output deser_en, edge_cnt, prescale, sampled_bit, data_len, msb_first,
`ifdef RX_DESER_PARITY_EN
        output par_odd,
        input  par_calc,
`endif
        input  P_DATA, data_done, busy
    );

    modport slave (
        input  deser_en, edge_cnt, prescale, sampled_bit, data_len, msb_first,
`ifdef RX_DESER_PARITY_EN
        input  par_odd,
        output par_calc,
`endif
        output P_DATA, data_done, busy
    );
endinterface

// File: rtl/rx_deser_param.sv
// Parametrised RX deserializer: collects len bits LSB- or MSB-first, publishes P_DATA on completion.
// Define RX_DESER_PARITY_EN to add the par_odd input and registered par_calc output.
module rx_deser_param
    import rx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PRESCALE_W = 6,
    parameter int LEN_W      = $clog2(DATA_W + 1)
) (
    input  logic        CLK,
    input  logic        RST,
    rx_deser_if.slave   bus
);

    rx_deser_state_e       r_state, w_state_nxt;
    logic [DATA_W-1:0]     r_shreg, w_shreg_nxt;
    logic [DATA_W-1:0]     r_pdata;
    logic [LEN_W-1:0]      r_bit_idx, r_len;
    logic                  r_mode;
    logic [LEN_W-1:0]      w_len_clamp, w_cur_len, w_cur_idx, w_pos;
    logic                  w_cur_mode;
    logic [PRESCALE_W-1:0] w_pm1;
    logic                  w_latch, w_last;
    logic                  w_busy, w_done;

    assign w_pm1       = bus.prescale - PRESCALE_W'(1);
    // prescale==0 would wrap to all-ones; suppress instead of latching.
    assign w_latch     = bus.deser_en && (bus.prescale != '0) && (bus.edge_cnt == w_pm1);
    assign w_len_clamp = LEN_W'(clamp_len(int'(bus.data_len), DATA_W));
    assign w_last      = (r_state == SHIFT) && w_latch && (r_bit_idx == r_len - LEN_W'(1));

    // Frame parameters come from the live inputs on the IDLE->SHIFT edge, else from the captures.
    always_comb begin
        w_cur_len   = (r_state == IDLE) ? w_len_clamp   : r_len;
        w_cur_mode  = (r_state == IDLE) ? bus.msb_first : r_mode;
        w_cur_idx   = (r_state == IDLE) ? '0            : r_bit_idx;
        w_pos       = w_cur_mode ? (w_cur_len - LEN_W'(1) - w_cur_idx) : w_cur_idx;
        w_shreg_nxt = (r_state == IDLE) ? '0 : r_shreg;
        for (int i = 0; i < DATA_W; i++) begin
            if (LEN_W'(i) == w_pos) begin
                w_shreg_nxt[i] = bus.sampled_bit;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.deser_en) w_state_nxt = SHIFT;
            SHIFT: begin
                if (!bus.deser_en)  w_state_nxt = IDLE;
                else if (w_last)    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == SHIFT);
        w_done = (r_state == DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_len     <= LEN_W'(DATA_W);
            r_mode    <= 1'b0;
            r_pdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.deser_en) begin
                        r_len     <= w_len_clamp;
                        r_mode    <= bus.msb_first;
                        r_shreg   <= w_latch ? w_shreg_nxt : '0;
                        r_bit_idx <= w_latch ? LEN_W'(1) : '0;
                    end
                end
                SHIFT: begin
                    if (!bus.deser_en) begin
                        r_shreg   <= '0;
                        r_bit_idx <= '0;
                    end else if (w_last) begin
                        r_pdata   <= w_shreg_nxt;
                        r_shreg   <= '0;
                        r_bit_idx <= '0;
                    end else if (w_latch) begin
                        r_shreg   <= w_shreg_nxt;
                        r_bit_idx <= r_bit_idx + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RX_DESER_PARITY_EN
    logic r_par_odd, r_par;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_par_odd <= 1'b0;
            r_par     <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.deser_en) begin
                r_par_odd <= bus.par_odd;
            end
            if (w_last) begin
                r_par <= (^w_shreg_nxt) ^ r_par_odd;
            end
        end
    end

    assign bus.par_calc = r_par;
`endif

    assign bus.P_DATA    = r_pdata;
    assign bus.data_done = w_done;
    assign bus.busy      = w_busy;

endmodule

// File: doc/rx_deser_param.md
Name: rx_deser_param

Overview:
Parametrised successor to the UART RX deserializer. It collects a runtime-selectable number of sampled bits, LSB-first or MSB-first, into a shadow shift register. P_DATA is updated only when a word completes, and a one-cycle data_done strobe is raised at the same time. It sits between the edge/bit counter and data sampler (upstream) and the RX FSM and parity/stop checkers (downstream).

Parameters:
DATA_W, 8, maximum data word width in bits (legal 5..16).
PRESCALE_W, 6, width of the prescale and edge_cnt buses.
LEN_W, $clog2(DATA_W+1), width of data_len.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
deser_en  in  1  enable from the RX FSM; high for the whole data phase.
edge_cnt  in  PRESCALE_W  oversample edge counter.
prescale  in  PRESCALE_W  oversampling ratio.
sampled_bit  in  1  voted bit from the data sampler.
data_len  in  LEN_W  bits per word for this frame.
msb_first  in  1  0 = LSB-first (UART), 1 = MSB-first.
P_DATA  out  DATA_W  last completed word, right-aligned, upper bits zero.
data_done  out  1  one-cycle strobe; P_DATA is new this cycle.
busy  out  1  high while in SHIFT.

Behaviour:
- Reset (RST=1, asynchronous): P_DATA=0, data_done=0, busy=0, bit_idx=0, shreg=0, state=IDLE.
- latch = deser_en && (edge_cnt == prescale-1), computed modulo 2^PRESCALE_W.
- prescale==0 is illegal. latch is forced to 0 for prescale==0; no X propagation.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT when deser_en=1.
    - On this edge: capture len_q = data_len and mode_q = msb_first, clear shreg and bit_idx.
    - If data_len<5 or data_len>DATA_W, len_q = DATA_W (clamp).
    - A latch in the same cycle is not lost: the bit is written at index 0.
  - SHIFT, on latch:
    - LSB-first: write shreg[bit_idx] = sampled_bit.
    - MSB-first: write shreg[len_q-1-bit_idx] = sampled_bit.
    - Then bit_idx++.
  - SHIFT -> DONE on the latch that writes bit_idx == len_q-1.
    - On that same edge: P_DATA <= final shreg value including the new bit, data_done <= 1.
    - Latency: P_DATA and data_done are valid the cycle after the final latch condition.
  - SHIFT -> IDLE if deser_en falls before completion (abort).
    - P_DATA is unchanged, no data_done, shreg and bit_idx are cleared.
  - DONE -> IDLE unconditionally after one cycle.
    - data_done returns to 0.
    - Latches during DONE are ignored.
    - A new frame needs deser_en high while in IDLE.
- data_len and msb_first changes mid-frame have no effect until the next IDLE->SHIFT transition.
- Bits above len_q in P_DATA are always 0.
- busy = (state==SHIFT).
- Simultaneous events: RST dominates everything. Abort, i.e. deser_en low, dominates latch, since latch requires deser_en.

Optional Feature:
Macro: RX_DESER_PARITY_EN.
- Defined:
  - Adds output par_calc (1 bit) and input par_odd (1 bit).
  - par_calc = XOR of the len_q data bits, inverted if par_odd was 1 at frame start (captured with data_len).
  - par_calc is registered alongside P_DATA and updates with data_done.
  - Reset value 0.
- Undefined: the ports do not exist and no parity logic is synthesised.

Decomposition:
- Shared package rx_pkg:
  - typedef enum rx_deser_state_e {IDLE, SHIFT, DONE}.
  - Constants MIN_DATA_LEN=5 and the DATA_W default.
  - Function clamp_len().
- The top module holds the FSM, shreg, and the P_DATA/par_calc registers.
- No sub-module is needed. The latch decode is a single assign.

Test Plan:
1. DATA_W=8, prescale=8, data_len=8, msb_first=0, stream 1,0,1,0,1,1,0,0 -> P_DATA=0x35, data_done high for exactly 1 cycle, one cycle after the 8th latch.
2. Same stream, msb_first=1 -> P_DATA=0xAC; busy high from the first cycle of deser_en until DONE.
3. data_len=5, msb_first=0, stream 1,0,1,1,0 -> P_DATA=0x0D, bits[7:5]=0; data_len=3 -> clamped to 8, word completes only after 8 latches.
4. Complete 0x35, then start a frame and drop deser_en after 3 latches -> P_DATA stays 0x35, no data_done, next full frame 0xFF -> P_DATA=0xFF.
5. Assert RST after 4 latches -> outputs return to 0 immediately, without waiting for a clock edge; after release, a full frame 0x5A completes normally.
6. With RX_DESER_PARITY_EN defined: 0x35 with par_odd=0 -> par_calc=0; 0x37 with par_odd=0 -> par_calc=1; 0x35 with par_odd=1 -> par_calc=1.
